pulse_event_scheduler: RTL
==========================

# pulse_event_scheduler

Collects one-cycle event pulses from up to NCH noise-filtered falling-edge detector channels and serialises them onto a single valid/ready event stream tagged with the channel number. It is the sequencing and sharing stage between the per-pin edge detectors and the single downstream consumer (interrupt logic or event FIFO). Channels are served round-robin. Events that arrive while a channel is already pending are merged and counted as overflows.

## Interface
- NCH, 4: number of event channels (2..16)
- CW, $clog2(NCH): width of channel index
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  NCH  per-channel enable mask
- evt  in  NCH  one-cycle event pulses from detectors, synchronous to clk
- clr_ovf  in  1  synchronous clear of ovf_cnt
- out_valid  out  1  event offered downstream
- out_ready  in  1  downstream accepts when high with out_valid
- out_ch  out  CW  channel index of offered event
- out_ts  out  16  capture timestamp of offered event (only with PES_TIMESTAMP_EN)
- ovf_cnt  out  8  saturating count of merged (lost) events

## Operation
- Reset values: out_valid=0, out_ch=0, out_ts=0, ovf_cnt=0, pending=0, rr pointer=0, state IDLE, timestamp counter=0.
- Pending capture, per channel i, each edge:
  - evt[i]&&en[i] sets pending[i].
  - Overflow condition: pending[i] already 1 and not being cleared by acceptance this cycle. Then pending stays 1, the event is merged, and ovf_cnt increments, saturating at 255.
  - evt[i] on the same edge that channel i is accepted: pending[i] stays 1 (the new event is queued). No overflow.
  - en[i]=0 clears pending[i] unless i is the channel currently offered. No overflow is counted.
  - Several channels overflowing on the same edge add only 1 to ovf_cnt.
  - clr_ovf wins over a simultaneous increment, so the result is 0.
- FSM:
  - IDLE:
    - If any pending bit is set, select the first pending channel at or after the rr pointer, wrapping modulo NCH.
    - Register out_ch (and out_ts) and set out_valid=1.
    - Go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - Hold out_valid=1 and keep out_ch/out_ts stable until out_valid&&out_ready.
    - On acceptance: clear pending[out_ch] (subject to the re-arm rule above), set rr pointer to (out_ch+1) mod NCH, drive out_valid=0, and go to IDLE.
- An offer is never retracted. Disabling the offered channel does not abort the offer, and it completes normally.

## Timing
- Latency: evt[i] sampled at edge E0 gives pending[i] high after E0, and out_valid high after E1. Two cycles in total.
- Throughput: at most one event per 2 cycles, because of the mandatory IDLE cycle between offers.
- out_ready may be high before out_valid. Acceptance occurs on the first edge where both are high.
- Asynchronous reset mid-offer drops the offer and all pending events immediately. No partial handshake completes.
- out_ch is stable for the whole time out_valid is high.

## Configuration
- PES_TIMESTAMP_EN defined:
  - Adds a free-running 16-bit counter that starts at 0 and wraps 0xFFFF to 0.
  - Adds one 16-bit capture register per channel. It is loaded with the counter value when pending[i] goes 0 to 1, or is re-armed on acceptance.
  - Merged (overflow) events do not update the capture register.
  - out_ts presents the granted channel's capture register, loaded together with out_ch.
- PES_TIMESTAMP_EN undefined: no counter, no capture registers, and no out_ts port. All other behaviour is identical.

## Test plan
- Single event: NCH=4, en=4'hF, evt=4'b0100 for 1 cycle, out_ready=1 → out_valid high 2 cycles later for exactly 1 cycle, out_ch=2, ovf_cnt=0.
- Round-robin fairness: evt=4'b1111 in one cycle, out_ready=1 → out_ch sequence 0,1,2,3, one grant every 2 cycles. Then evt=4'b0011 after the pointer is at 0 → grants 0,1. Pointer wrap is verified.
- Backpressure and overflow: out_ready=0, evt[1] pulsed 3 times → one offer out_ch=1 stays stable, ovf_cnt=2. Raise out_ready → one acceptance, ovf_cnt stays 2. Then clr_ovf → 0.
- Re-arm on accept: evt[3] pulsed on the same edge channel 3 is accepted → second offer with out_ch=3 follows, ovf_cnt unchanged.
- Enable masking and reset: en=4'b1110 with evt[0] → no offer. Set pending[2], drop en[2] before its offer → no offer. Assert reset_n low during OFFER → out_valid=0 immediately, and no offer after release.
- Timestamp (PES_TIMESTAMP_EN): evt[0] at counter=0x0010, second evt[0] at 0x0014 while pending → out_ts=0x0010, ovf_cnt=1. Counter wraps 0xFFFF→0x0000 with the correct out_ts across the wrap.

Source files
------------

// File: rtl/pulse_event_scheduler.sv
// Round-robin serialiser of per-channel event pulses onto one valid/ready stream.
// Define PES_TIMESTAMP_EN to add the 16-bit capture timestamp and the out_ts port.
module pulse_event_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] en,
  input  logic [NCH-1:0] evt,
  input  logic           clr_ovf,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_ch,
  output logic [7:0]     ovf_cnt
`ifdef PES_TIMESTAMP_EN
  ,
  output logic [15:0]    out_ts
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam int CW1 = CW + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic [CW-1:0]  rr_q, rr_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [7:0]     ovf_q, ovf_d;

  logic           accept;
  logic           ovf_hit;
  logic           grant_found;
  logic [CW-1:0]  grant_ch;
  logic [CW1-1:0] scan_idx;
  logic [NCH-1:0] req;

`ifdef PES_TIMESTAMP_EN
  logic [NCH-1:0] arm;
  logic [15:0]    ts_cnt_q;
  logic [15:0]    cap_q [NCH];
  logic [15:0]    out_ts_q;
`endif

  assign accept    = (state_q == OFFER) && out_ready;
  assign req       = pending_q & en;
  assign out_valid = (state_q == OFFER);
  assign out_ch    = out_ch_q;
  assign ovf_cnt   = ovf_q;

  // Pending capture: set on enabled events, merge repeats, re-arm on accept.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pending_d = pending_q;
    ovf_hit   = 1'b0;
`ifdef PES_TIMESTAMP_EN
    arm       = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      if (!en[i] && !((state_q == OFFER) && (out_ch_q == CW'(i)))) begin
        pending_d[i] = 1'b0;
      end else begin
        if (accept && (out_ch_q == CW'(i))) begin
          pending_d[i] = 1'b0;
        end
        if (evt[i] && en[i]) begin
          if (pending_q[i] && !(accept && (out_ch_q == CW'(i)))) begin
            ovf_hit = 1'b1;
          end
`ifdef PES_TIMESTAMP_EN
          else begin
            arm[i] = 1'b1;
          end
`endif
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  // Overflow counter: one increment per edge regardless of how many channels merged.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = '0;
    end else if (ovf_hit && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // First enabled pending channel at or after the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = CW1'(rr_q) + CW1'(k);
      if (scan_idx >= CW1'(NCH)) begin
        scan_idx = scan_idx - CW1'(NCH);
      end
      if (!grant_found && req[scan_idx[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = scan_idx[CW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    out_ch_d = out_ch_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d  = OFFER;
          out_ch_d = grant_ch;
        end
      end
      OFFER: begin
        if (out_ready) begin
          state_d = IDLE;
          rr_d    = (out_ch_q == CW'(NCH - 1)) ? '0 : out_ch_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      out_ch_q  <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_ch_q  <= out_ch_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef PES_TIMESTAMP_EN
  // NOTE: the capture bank is only NCH small registers, so it is reset like other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
      out_ts_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      for (int i = 0; i < NCH; i++) begin
        if (arm[i]) begin
          cap_q[i] <= ts_cnt_q;
        end
      end
      if ((state_q == IDLE) && grant_found) begin
        out_ts_q <= cap_q[grant_ch];
      end
    end
  end

  assign out_ts = out_ts_q;
`endif

endmodule
